// File: rtl/disp_bus_arb.sv
// disp_bus_arb: two-port burst arbiter for the display write bus.
// Port 0 is the power-on/init sequencer, port 1 the host stream. Port 1 is
// held off until init_done. Whole bursts are granted round-robin, and a
// watchdog revokes a grant whose owner stops presenting beats mid-burst.
module disp_bus_arb #(
  parameter int DW         = 9,
  parameter int CLK_FREQ   = 12000000,
  parameter int TIMEOUT_US = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_done,
  input  logic          p0_valid,
  input  logic [DW-1:0] p0_data,
  input  logic          p0_last,
  output logic          p0_ready,
  input  logic          p1_valid,
  input  logic [DW-1:0] p1_data,
  input  logic          p1_last,
  output logic          p1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [1:0]    grant,
  output logic          err_timeout
);

  // Stall limit in cycles, never below one so the watchdog always fires.
  localparam longint TC_RAW         = (longint'(CLK_FREQ) * longint'(TIMEOUT_US)) / 1000000;
  localparam int     TIMEOUT_CYCLES = (TC_RAW < 1) ? 1 : int'(TC_RAW);
  localparam int     CW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rr_last;
  logic          rr_last_nxt;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_cnt_nxt;
  logic          err_nxt;
  logic          p1_eligible;

  // Host port only competes once the panel has been initialised.
  assign p1_eligible = p1_valid & init_done;

  // Route the owning port onto the display bus; nothing is driven in IDLE.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    grant     = 2'b00;
    case (state)
      GNT0: begin
        out_valid = p0_valid;
        out_data  = p0_data;
        out_last  = p0_last;
        p0_ready  = out_ready;
        grant     = 2'b01;
      end
      GNT1: begin
        out_valid = p1_valid;
        out_data  = p1_data;
        out_last  = p1_last;
        p1_ready  = out_ready;
        grant     = 2'b10;
      end
      default: ;
    endcase
  end

  // Pick the next owner in IDLE; in a grant, release on the final beat
  // transfer or when the owner has stalled for the full watchdog period.
  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    stall_cnt_nxt = stall_cnt;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        stall_cnt_nxt = '0;
        if (p0_valid && p1_eligible) begin
          state_nxt = rr_last ? GNT0 : GNT1;
        end else if (p0_valid) begin
          state_nxt = GNT0;
        end else if (p1_eligible) begin
          state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (out_valid) begin
          stall_cnt_nxt = '0;
          if (out_last && out_ready) begin
            state_nxt   = IDLE;
            rr_last_nxt = (state == GNT1);
          end
        end else if (stall_cnt == TC_LAST) begin
          state_nxt     = IDLE;
          rr_last_nxt   = (state == GNT1);
          stall_cnt_nxt = '0;
          err_nxt       = 1'b1;
        end else begin
          stall_cnt_nxt = stall_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        stall_cnt_nxt = '0;
      end
    endcase
  end

  // State, round-robin pointer, watchdog counter and timeout pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_last     <= rr_last_nxt;
      stall_cnt   <= stall_cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_disp_bus_arb.sv
// tb_disp_bus_arb: scoreboard bench for disp_bus_arb with a transaction-level
// ownership model and randomized burst traffic.
module tb_disp_bus_arb;

  localparam int DW         = 9;
  localparam int CLK_FREQ   = 120000;
  localparam int TIMEOUT_US = 100;
  localparam int TO_RAW     = (CLK_FREQ / 1000) * TIMEOUT_US / 1000;
  localparam int TO_CYC     = (TO_RAW < 1) ? 1 : TO_RAW;

  typedef logic [DW:0] beat_t;

  logic          clk;
  logic          reset;
  logic          init_done;
  logic          p0_valid;
  logic [DW-1:0] p0_data;
  logic          p0_last;
  logic          p0_ready;
  logic          p1_valid;
  logic [DW-1:0] p1_data;
  logic          p1_last;
  logic          p1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [1:0]    grant;
  logic          err_timeout;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    err_seen = 0;
  int    ready_mode = 0;
  bit    abort = 0;
  beat_t expq0[$];
  beat_t expq1[$];

  disp_bus_arb #(
    .DW(DW),
    .CLK_FREQ(CLK_FREQ),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_done(init_done),
    .p0_valid(p0_valid),
    .p0_data(p0_data),
    .p0_last(p0_last),
    .p0_ready(p0_ready),
    .p1_valid(p1_valid),
    .p1_data(p1_data),
    .p1_last(p1_last),
    .p1_ready(p1_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .grant(grant),
    .err_timeout(err_timeout)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #900000;
    $display("[TB] FAIL global_watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Display-side backpressure: always ready, random, or stalled.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Ownership model: who owns the bus, who finished last, how long the owner
  // has gone without presenting a beat.
  int m_owner = -1;
  int m_rr = 1;
  int m_stall = 0;
  bit m_err = 0;
  bit m_v;
  bit m_l;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1;
      m_rr    = 1;
      m_stall = 0;
      m_err   = 0;
    end else begin
      m_err = 0;
      if (m_owner < 0) begin
        m_stall = 0;
        if (p0_valid && p1_valid && init_done) m_owner = 1 - m_rr;
        else if (p0_valid)                     m_owner = 0;
        else if (p1_valid && init_done)        m_owner = 1;
      end else begin
        m_v = (m_owner == 0) ? p0_valid : p1_valid;
        m_l = (m_owner == 0) ? p0_last  : p1_last;
        if (m_v) begin
          m_stall = 0;
          if (m_l && out_ready) begin
            m_rr    = m_owner;
            m_owner = -1;
          end
        end else begin
          m_stall++;
          if (m_stall == TO_CYC) begin
            m_err   = 1;
            m_rr    = m_owner;
            m_owner = -1;
            m_stall = 0;
          end
        end
      end
    end
  end

  // Monitor: routing/grant checks each cycle, scoreboard pop on each beat.
  logic [1:0] e_grant;
  logic       e_ov;
  beat_t      mon_b;
  always @(negedge clk) begin
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_ov    = (m_owner == 0) ? p0_valid : (m_owner == 1) ? p1_valid : 1'b0;
    checkOutput("grant", 32'(grant), 32'(e_grant));
    checkOutput("p0_ready", 32'(p0_ready), 32'((m_owner == 0) && out_ready));
    checkOutput("p1_ready", 32'(p1_ready), 32'((m_owner == 1) && out_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(e_ov));
    checkOutput("err_timeout", 32'(err_timeout), 32'(m_err));
    if (reset && err_timeout) err_seen++;
    if (m_owner < 0) begin
      checkOutput("out_data_idle", 32'(out_data), 32'd0);
      checkOutput("out_last_idle", 32'(out_last), 32'd0);
    end
    if (out_valid && out_ready) begin
      if (m_owner < 0) begin
        checkOutput("spurious_beat", 32'(out_valid), 32'd0);
      end else if ((m_owner == 0 && expq0.size() == 0) || (m_owner == 1 && expq1.size() == 0)) begin
        checkOutput("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        mon_b = (m_owner == 0) ? expq0.pop_front() : expq1.pop_front();
        checkOutput("beat_data", 32'(out_data), 32'(mon_b[DW-1:0]));
        checkOutput("beat_last", 32'(out_last), 32'(mon_b[DW]));
      end
    end
  end

  task automatic drivePort(input int port, input bit v, input beat_t b);
    if (port == 0) begin
      p0_valid = v;
      p0_data  = b[DW-1:0];
      p0_last  = b[DW] & v;
    end else begin
      p1_valid = v;
      p1_data  = b[DW-1:0];
      p1_last  = b[DW] & v;
    end
  endtask

  // Requester: present one burst, holding each beat until it is accepted,
  // with optional random valid drops and one forced drop before beat force_at.
  task automatic applyStimulus(input int port, input int len, input int drop_pct,
                               input int drop_max, input int force_at, input int force_len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      int    waited;
      bit    done;
      if (i == force_at) begin
        drivePort(port, 1'b0, '0);
        repeat (force_len) @(posedge clk);
        #1;
        if (abort) return;
      end
      b[DW-1:0] = DW'($urandom);
      b[DW]     = (i == len - 1);
      if (port == 0) expq0.push_back(b);
      else           expq1.push_back(b);
      drivePort(port, 1'b1, b);
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (abort) begin
          drivePort(port, 1'b0, '0);
          return;
        end
        if ((port == 0) ? (p0_ready && p0_valid) : (p1_ready && p1_valid)) begin
          @(posedge clk);
          #1;
          done = 1'b1;
        end else if ($urandom_range(99) < drop_pct) begin
          int k;
          k = $urandom_range(drop_max, 1);
          @(posedge clk);
          #1;
          drivePort(port, 1'b0, b);
          repeat (k) @(posedge clk);
          #1;
          if (abort) return;
          drivePort(port, 1'b1, b);
          waited += k + 1;
        end else begin
          waited++;
        end
        if (!done && waited > 5000) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL beat_accept_bound: port %0d beat %0d got no accept expected accept within 5000 cycles", port, i);
          drivePort(port, 1'b0, '0);
          return;
        end
      end
    end
    drivePort(port, 1'b0, '0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int e0;
  int nb0;
  int nb1;

  initial begin
    reset     = 1'b0;
    init_done = 1'b0;
    drivePort(0, 1'b0, '0);
    drivePort(1, 1'b0, '0);
    doReset();

    $display("[TB] host port locked out before init");
    p1_valid = 1'b1;
    p1_data  = DW'($urandom);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("locked_grant", 32'(grant), 32'd0);
    p1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] init sequencer burst");
    applyStimulus(0, 3, 0, 1, -1, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] round-robin with both ports busy");
    doReset();
    init_done = 1'b1;
    fork
      for (int b = 0; b < 4; b++) applyStimulus(0, 2, 0, 1, -1, 0);
      for (int b = 0; b < 4; b++) applyStimulus(1, 2, 0, 1, -1, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("first_tie_port0", 32'(grant), 32'd1);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] watchdog on stalled host burst");
    e0 = err_seen;
    fork
      applyStimulus(1, 3, 0, 1, 1, 20);
      begin
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 2, 0, 1, -1, 0);
      end
    join
    repeat (5) @(posedge clk);
    #1;
    checkOutput("timeout_pulses", 32'(err_seen - e0), 32'd1);

    $display("[TB] slow display does not trip the watchdog");
    e0 = err_seen;
    ready_mode = 2;
    @(posedge clk);
    #1;
    fork
      applyStimulus(0, 2, 0, 1, -1, 0);
      begin
        repeat (2000) @(posedge clk);
        #1;
        checkOutput("stall_grant_held", 32'(grant), 32'd1);
        ready_mode = 0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_no_timeout", 32'(err_seen - e0), 32'd0);

    $display("[TB] async reset mid host burst");
    fork
      applyStimulus(1, 8, 0, 1, -1, 0);
      begin
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        abort = 1'b1;
        #1;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_p1_ready", 32'(p1_ready), 32'd0);
      end
    join
    expq0.delete();
    expq1.delete();
    @(negedge clk);
    reset = 1'b1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    fork
      applyStimulus(0, 2, 0, 1, -1, 0);
      applyStimulus(1, 2, 0, 1, -1, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("tie_after_reset", 32'(grant), 32'd1);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int it = 0; it < 20; it++) begin
      ready_mode = $urandom_range(1);
      init_done  = 1'b1;
      nb0 = $urandom_range(3, 1);
      nb1 = $urandom_range(3, 1);
      fork
        for (int b = 0; b < nb0; b++) applyStimulus(0, $urandom_range(5, 1), 10, 20, -1, 0);
        for (int b = 0; b < nb1; b++) applyStimulus(1, $urandom_range(5, 1), 10, 20, -1, 0);
        repeat (2) begin
          repeat ($urandom_range(30, 1)) @(posedge clk);
          #1;
          init_done = 1'b0;
          repeat ($urandom_range(30, 1)) @(posedge clk);
          #1;
          init_done = 1'b1;
        end
      join
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
    end
    ready_mode = 0;
    repeat (TO_CYC + 5) @(posedge clk);
    #1;
    checkOutput("queue0_drained", 32'(expq0.size()), 32'd0);
    checkOutput("queue1_drained", 32'(expq1.size()), 32'd0);
    checkOutput("final_grant", 32'(grant), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_bus_arb.md
Name: disp_bus_arb

Overview:
- Arbitrates the single display write bus between two requesters: port 0, the power-on/init sequencer (command writes), and port 1, the host pixel/command stream arriving from the USB side.
- Port 1 is locked out until the power-on controller signals init complete.
- After init complete, grants are whole bursts in round-robin order, with an idle-timeout watchdog on the granted port.
- Sits between pwr_on_ctl_mem and the host FIFO on the requester side, and the display bus driver on the output side.

Parameters:
- DW, 9, data width per beat (bit 8 = D/C flag, bits 7:0 = byte).
- CLK_FREQ, 12000000, clock frequency in Hz.
- TIMEOUT_US, 100, stall limit in µs for a granted port that drops valid mid-burst.
  - TIMEOUT_CYCLES = max(1, CLK_FREQ*TIMEOUT_US/1000000).
  - Defaults give 1200 cycles. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- init_done  in  1  level from power-on controller; 0 blocks port 1
- p0_valid  in  1  port 0 beat valid
- p0_data  in  DW  port 0 beat data
- p0_last  in  1  port 0 final beat of burst
- p0_ready  out  1  port 0 beat accepted
- p1_valid  in  1  port 1 beat valid
- p1_data  in  DW  port 1 beat data
- p1_last  in  1  port 1 final beat of burst
- p1_ready  out  1  port 1 beat accepted
- out_valid  out  1  to display driver
- out_data  out  DW  to display driver
- out_last  out  1  to display driver
- out_ready  in  1  display driver can accept
- grant  out  2  one-hot current owner; 00 = none
- err_timeout  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=00, rr_last=1 (port 0 wins the first tie), timeout counter=0, err_timeout=0.
  - All ready and valid outputs are 0 during reset; out_data/out_last are 0.
- States: IDLE, GNT0, GNT1. Transitions are registered; the datapath is combinational.
- Beat transfer occurs on a cycle where out_valid & out_ready.
- Datapath in GNTx:
  - out_valid = px_valid; out_data = px_data; out_last = px_last.
  - px_ready = out_ready; the other port's ready = 0.
- Datapath in IDLE: out_valid=0, both readys 0, out_data/out_last=0.
- IDLE decision, evaluated each cycle:
  - init_done=0: GNT0 if p0_valid; port 1 is ignored.
  - init_done=1, only one port valid: grant that port.
  - init_done=1, both valid: grant the port not equal to rr_last.
  - The grant takes effect the next cycle, so there is 1 cycle of arbitration latency. The first beat can transfer in the cycle after valid is first seen in IDLE.
- GNTx exit on a transfer with px_last=1:
  - Go to IDLE next cycle; rr_last=x.
  - No back-to-back regrant in the same cycle. Every burst costs one IDLE cycle.
- Timeout counter:
  - Counts cycles in GNTx with px_valid=0.
  - Clears on any cycle with px_valid=1. The out_ready stall does not count, since the display may be slow.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse err_timeout for 1 cycle, set rr_last=x, clear the counter.
- init_done falls while in GNT1: the current burst is allowed to finish (no abort). Port 1 is not regranted until init_done=1.
- init_done rises while in GNT0: no effect on the current burst.
- px_last=1 with out_ready=0: no exit. Exit happens only on the actual transfer.
- A valid that drops without a transfer is legal at the input; the arbiter does not check requester protocol.
- Reset asserted mid-burst: immediate return to the reset state. Any beat in flight is lost. Requesters must re-send.

Test Plan:
- Reset, then init_done=0; p1_valid=1 and p0 idle for 50 cycles → grant stays 00, p1_ready=0 throughout.
- init_done=0; port 0 sends a 3-beat burst, out_ready=1 → grant=01 one cycle after p0_valid; out_data matches 3 beats in order; IDLE for 1 cycle after the last beat; grant=00.
- init_done=1; both ports continuously valid with 2-beat bursts → grants alternate 01,10,01,10… with one idle cycle between; port 0 wins first after reset.
- Granted port 1 sends beat 1, then drops p1_valid; CLK_FREQ=120000, TIMEOUT_US=100 (12 cycles) → grant returns to 00 exactly 12 cycles after valid fell; err_timeout high for 1 cycle; a pending port 0 is then granted.
- GNT0, out_ready held 0 for 2000 cycles with p0_valid=1 → no timeout, grant held, p0_ready=0; transfer completes when out_ready=1.
- Reset asserted in the middle of a port 1 burst (async, between clock edges) → grant=00, out_valid=0 immediately; after release, port 0 wins the first tie.
